// File: rtl/apb_requester.sv
// APB4 requester: converts a valid/ready command stream into APB transfers on one
// completer and returns exactly one response per accepted command.
module apb_requester #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                    pclk,
    input  logic                    presetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_strb,
    input  logic [2:0]              cmd_prot,
    output logic                    rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    psel,
    output logic                    penable,
    output logic                    pwrite,
    output logic [ADDR_WIDTH-1:0]   paddr,
    output logic [DATA_WIDTH-1:0]   pwdata,
    output logic [DATA_WIDTH/8-1:0] pstrb,
    output logic [2:0]              pprot,
    input  logic [DATA_WIDTH-1:0]   prdata,
    input  logic                    pready,
    input  logic                    pslverr
);

    localparam int unsigned STRB_WIDTH  = DATA_WIDTH / 8;
    localparam int unsigned ALIGN_BITS  = $clog2(STRB_WIDTH);
    localparam int unsigned WAIT_WIDTH  = 16;
    localparam int unsigned ERR_W       = 3;
    localparam bit          TIMEOUT_EN  = (TIMEOUT_CYCLES != 0);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << ALIGN_BITS) - 1);
    localparam logic [WAIT_WIDTH-1:0] TO_LAST    = WAIT_WIDTH'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [WAIT_WIDTH-1:0]  wait_cnt;
    logic [ERR_W-1:0]       err_cnt;

    logic accept;
    logic misaligned;
    logic load;
    logic mis_accept;
    logic complete;
    logic abort;
    logic emit_err;

    assign cmd_ready = presetn && ((state == IDLE) || ((state == ACCESS) && pready));

    // Next-state and transfer-event decode
    always_comb begin
        state_nxt  = state;
        load       = 1'b0;
        mis_accept = 1'b0;
        complete   = 1'b0;
        abort      = 1'b0;
        emit_err   = 1'b0;
        accept     = cmd_valid && cmd_ready;
        misaligned = |(cmd_addr & ALIGN_MASK);

        case (state)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        mis_accept = 1'b1;
                    end else begin
                        load      = 1'b1;
                        state_nxt = SETUP;
                    end
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (pready) begin
                    complete  = 1'b1;
                    state_nxt = IDLE;
                    if (accept) begin
                        if (misaligned) begin
                            mis_accept = 1'b1;
                        end else begin
                            load      = 1'b1;
                            state_nxt = SETUP;
                        end
                    end
                end else if (TIMEOUT_EN && (wait_cnt >= TO_LAST)) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Misalignment errors queue behind a completion or timeout response in the same slot
        if (!complete && !abort && ((err_cnt != '0) || (mis_accept && (state == IDLE)))) begin
            emit_err = 1'b1;
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Saturating wait-state counter, cleared on each SETUP entry
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            wait_cnt <= '0;
        end else if (load) begin
            wait_cnt <= '0;
        end else if ((state == ACCESS) && !pready && (wait_cnt != '1)) begin
            wait_cnt <= wait_cnt + WAIT_WIDTH'(1);
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            err_cnt <= '0;
        end else begin
            err_cnt <= err_cnt + ERR_W'(mis_accept) - ERR_W'(emit_err);
        end
    end

    // Registered APB request signals
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            psel    <= 1'b0;
            penable <= 1'b0;
            pwrite  <= 1'b0;
            paddr   <= '0;
            pwdata  <= '0;
            pstrb   <= '0;
            pprot   <= '0;
        end else begin
            psel    <= (state_nxt != IDLE);
            penable <= (state_nxt == ACCESS);
            if (load) begin
                pwrite <= cmd_write;
                paddr  <= cmd_addr;
                pwdata <= cmd_wdata;
                pstrb  <= cmd_write ? cmd_strb : STRB_WIDTH'(0);
                pprot  <= cmd_prot;
            end
        end
    end

    // Registered single-cycle response
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
        end else begin
            rsp_valid   <= complete || abort || emit_err;
            rsp_err     <= complete ? pslverr : (abort || emit_err);
            rsp_timeout <= abort;
            rsp_rdata   <= (complete && !pwrite && !pslverr) ? prdata : DATA_WIDTH'(0);
        end
    end

endmodule

// File: tb/tb_apb_requester.sv
// Directed self-checking bench for apb_requester with default parameters.
module tb_apb_requester;

    logic        pclk;
    logic        presetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_strb;
    logic [2:0]  cmd_prot;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_cmp = 0;
    int n_err = 0;

    apb_requester dut (
        .pclk(pclk), .presetn(presetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb), .cmd_prot(cmd_prot),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
        .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input logic [2:0] prot);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wd;
        cmd_strb  = strb;
        cmd_prot  = prot;
    endtask

    task automatic test_reset();
        presetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        cmd_strb = '0; cmd_prot = '0; prdata = '0; pready = 1'b1; pslverr = 1'b0;
        tick(); tick();
        n_cmp++;
        if ({cmd_ready, psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
             rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== '0) begin
            n_err++; $display("FAIL reset_outputs: got psel=%b pen=%b paddr=%h rsp_valid=%b cmd_ready=%b exp all 0",
                              psel, penable, paddr, rsp_valid, cmd_ready);
        end
        presetn = 1'b1;
        #1;
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL reset_release_ready: got %b exp 1", cmd_ready);
        end
    endtask

    task automatic test_write();
        set_cmd(1'b1, 32'h8, 32'hDEADBEEF, 4'hF, 3'd2);
        pready = 1'b1;
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if ({psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, cmd_ready} !==
            {3'b101, 32'h8, 32'hDEADBEEF, 4'hF, 3'd2, 1'b0, 1'b0}) begin
            n_err++; $display("FAIL wr_setup: got sel=%b en=%b wr=%b addr=%h wd=%h strb=%h prot=%h rv=%b rdy=%b exp 1 0 1 8 deadbeef f 2 0 0",
                              psel, penable, pwrite, paddr, pwdata, pstrb, pprot, rsp_valid, cmd_ready);
        end
        tick();
        n_cmp++;
        if ({psel, penable, rsp_valid, cmd_ready} !== 4'b1101) begin
            n_err++; $display("FAIL wr_access: got sel=%b en=%b rv=%b rdy=%b exp 1 1 0 1",
                              psel, penable, rsp_valid, cmd_ready);
        end
        tick();
        n_cmp++;
        if ({psel, penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, paddr} !==
            {5'b00100, 32'h0, 32'h8}) begin
            n_err++; $display("FAIL wr_resp: got sel=%b en=%b rv=%b err=%b to=%b rd=%h addr=%h exp 0 0 1 0 0 0 8",
                              psel, penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata, paddr);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL wr_resp_pulse: got %b exp 0", rsp_valid);
        end
    endtask

    task automatic test_read_wait();
        int hi = 0;
        int rv = 0;
        set_cmd(1'b0, 32'h8, 32'h0, 4'hF, 3'd0);
        pready = 1'b0;
        prdata = 32'hDEADBEEF;
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if ({psel, penable, pwrite, pstrb, cmd_ready} !== {3'b100, 4'h0, 1'b0}) begin
            n_err++; $display("FAIL rd_setup: got sel=%b en=%b wr=%b strb=%h rdy=%b exp 1 0 0 0 0",
                              psel, penable, pwrite, pstrb, cmd_ready);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            if (penable === 1'b1) hi++;
            if (rsp_valid === 1'b1) rv++;
            if (i == 3) pready = 1'b1;
        end
        n_cmp++;
        if (hi != 4 || rv != 0) begin
            n_err++; $display("FAIL rd_wait_penable: got hi=%0d rsp=%0d exp hi=4 rsp=0", hi, rv);
        end
        tick();
        n_cmp++;
        if ({penable, psel, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {5'b00100, 32'hDEADBEEF}) begin
            n_err++; $display("FAIL rd_resp: got en=%b sel=%b rv=%b err=%b to=%b rd=%h exp 0 0 1 0 0 deadbeef",
                              penable, psel, rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        pready = 1'b1;
        prdata = 32'h0;
        set_cmd(1'b1, 32'h4, 32'h12345678, 4'h3, 3'd1);
        tick();
        set_cmd(1'b0, 32'h4, 32'h0, 4'hF, 3'd0);
        n_cmp++;
        if ({psel, penable, pwrite, pstrb, cmd_ready} !== {3'b101, 4'h3, 1'b0}) begin
            n_err++; $display("FAIL b2b_setup1: got sel=%b en=%b wr=%b strb=%h rdy=%b exp 1 0 1 3 0",
                              psel, penable, pwrite, pstrb, cmd_ready);
        end
        tick();
        n_cmp++;
        if ({psel, penable, cmd_ready} !== 3'b111) begin
            n_err++; $display("FAIL b2b_access1: got sel=%b en=%b rdy=%b exp 1 1 1", psel, penable, cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        prdata = 32'hCAFEF00D;
        n_cmp++;
        if ({psel, penable, pwrite, pstrb, paddr, rsp_valid, rsp_err, rsp_rdata} !==
            {3'b100, 4'h0, 32'h4, 2'b10, 32'h0}) begin
            n_err++; $display("FAIL b2b_setup2: got sel=%b en=%b wr=%b strb=%h addr=%h rv=%b err=%b rd=%h exp 1 0 0 0 4 1 0 0",
                              psel, penable, pwrite, pstrb, paddr, rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
        n_cmp++;
        if ({psel, penable, rsp_valid} !== 3'b110) begin
            n_err++; $display("FAIL b2b_access2: got sel=%b en=%b rv=%b exp 1 1 0", psel, penable, rsp_valid);
        end
        tick();
        n_cmp++;
        if ({psel, rsp_valid, rsp_err, rsp_rdata} !== {3'b010, 32'hCAFEF00D}) begin
            n_err++; $display("FAIL b2b_resp2: got sel=%b rv=%b err=%b rd=%h exp 0 1 0 cafef00d",
                              psel, rsp_valid, rsp_err, rsp_rdata);
        end
        tick();
    endtask

    task automatic test_slverr();
        pready = 1'b1;
        pslverr = 1'b1;
        prdata = 32'hFFFFFFFF;
        set_cmd(1'b0, 32'h10, 32'h0, 4'h0, 3'd0);
        tick();
        cmd_valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {3'b110, 32'h0}) begin
            n_err++; $display("FAIL slverr_resp: got rv=%b err=%b to=%b rd=%h exp 1 1 0 0",
                              rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
        end
        pslverr = 1'b0;
        tick();
    endtask

    task automatic test_misaligned();
        set_cmd(1'b1, 32'h6, 32'h55, 4'hF, 3'd0);
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL mis_ready: got %b exp 1", cmd_ready);
        end
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if ({psel, penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== {5'b00110, 32'h0}) begin
            n_err++; $display("FAIL mis_resp: got sel=%b en=%b rv=%b err=%b to=%b rd=%h exp 0 0 1 1 0 0",
                              psel, penable, rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
        end
        tick();
        n_cmp++;
        if ({psel, rsp_valid} !== 2'b00) begin
            n_err++; $display("FAIL mis_after: got sel=%b rv=%b exp 0 0", psel, rsp_valid);
        end
    endtask

    task automatic test_chain_misaligned();
        pready = 1'b1;
        set_cmd(1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, 3'd0);
        tick();
        cmd_addr = 32'h2;
        tick();
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if ({psel, rsp_valid, rsp_err} !== 3'b010) begin
            n_err++; $display("FAIL chain_mis_first: got sel=%b rv=%b err=%b exp 0 1 0", psel, rsp_valid, rsp_err);
        end
        tick();
        n_cmp++;
        if ({psel, rsp_valid, rsp_err, rsp_timeout} !== 4'b0110) begin
            n_err++; $display("FAIL chain_mis_second: got sel=%b rv=%b err=%b to=%b exp 0 1 1 0",
                              psel, rsp_valid, rsp_err, rsp_timeout);
        end
        tick();
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++; $display("FAIL chain_mis_end: got %b exp 0", rsp_valid);
        end
    endtask

    task automatic test_timeout();
        int hi = 0;
        int rv = 0;
        bit seen = 1'b0;
        int rv_after = 0;
        pready = 1'b0;
        set_cmd(1'b0, 32'hC, 32'h0, 4'h0, 3'd0);
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            tick();
            if (rsp_valid === 1'b1) seen = 1'b1;
            else if (penable === 1'b1) hi++;
        end
        n_cmp++;
        if (!seen || hi != 16) begin
            n_err++; $display("FAIL timeout_len: got seen=%b access=%0d exp seen=1 access=16", seen, hi);
        end
        n_cmp++;
        if ({psel, penable, rsp_err, rsp_timeout, rsp_rdata} !== {4'b0011, 32'h0}) begin
            n_err++; $display("FAIL timeout_resp: got sel=%b en=%b err=%b to=%b rd=%h exp 0 0 1 1 0",
                              psel, penable, rsp_err, rsp_timeout, rsp_rdata);
        end
        pready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (rsp_valid === 1'b1 || psel === 1'b1) rv++;
        end
        n_cmp++;
        if (rv != 0) begin
            n_err++; $display("FAIL timeout_late_pready: got activity=%0d exp 0", rv);
        end
        // Reset in the middle of SETUP of the next command
        set_cmd(1'b1, 32'h20, 32'h11223344, 4'hF, 3'd7);
        tick();
        cmd_valid = 1'b0;
        n_cmp++;
        if ({psel, penable} !== 2'b10) begin
            n_err++; $display("FAIL rst_mid_setup_pre: got sel=%b en=%b exp 1 0", psel, penable);
        end
        #2 presetn = 1'b0;
        #1;
        n_cmp++;
        if ({cmd_ready, psel, penable, pwrite, paddr, pwdata, pstrb, pprot,
             rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== '0) begin
            n_err++; $display("FAIL rst_mid_setup: got sel=%b en=%b addr=%h wd=%h rdy=%b exp all 0",
                              psel, penable, paddr, pwdata, cmd_ready);
        end
        tick();
        presetn = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rsp_valid === 1'b1 || psel === 1'b1) rv_after++;
        end
        n_cmp++;
        if (rv_after != 0) begin
            n_err++; $display("FAIL rst_no_resp: got activity=%0d exp 0", rv_after);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_wait();
        test_back_to_back();
        test_slverr();
        test_misaligned();
        test_chain_misaligned();
        test_timeout();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp completion");
        $fatal(1);
    end

endmodule
